// File: rtl/uart_rx.sv
// Purpose : 8N1 UART receiver; mid-bit sampling, LSB-first assembly, ready/ack byte handoff.
// Latency : start edge on rx_in to done pulse = 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 clocks.
// Backpres: none on the line; an unacknowledged byte is overwritten by the next good frame and overrun is set.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   rx_en      receiver enable; low aborts any frame in progress
//   rx_in      serial line (asynchronous, idles high)
//   rd_ack     consumer acknowledge; clears ready and overrun
//   data_out   last good received byte
//   ready      sticky: unread byte present in data_out
//   done       one-cycle pulse per good frame
//   busy       receiver is inside a frame (state != IDLE)
//   frame_err  one-cycle pulse on a bad stop bit
//   overrun    sticky: a good frame completed while ready was still set
module uart_rx #(
    parameter int CLKS_PER_BIT = 10417
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_en,
    input  logic       rx_in,
    input  logic       rd_ack,
    output logic [7:0] data_out,
    output logic       ready,
    output logic       done,
    output logic       busy,
    output logic       frame_err,
    output logic       overrun
);

    localparam int CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int HALF = CLKS_PER_BIT / 2;

    localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          rx_m;
    logic          rx_s;

    // Two-flop synchronizer, preset to the idle-high line level so reset
    // release never looks like a start bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx_in;
            rx_s <= rx_m;
        end
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            data_out  <= '0;
            ready     <= 1'b0;
            done      <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            done      <= 1'b0;
            frame_err <= 1'b0;

            if (rd_ack) begin
                ready   <= 1'b0;
                overrun <= 1'b0;
            end

            if (!rx_en && state != IDLE) begin
                // Abort: frame discarded, handshake state kept.
                state   <= IDLE;
                cnt     <= '0;
                bit_idx <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        if (rx_en && !rx_s) begin
                            state <= START;
                        end
                    end

                    START: begin
                        if (cnt == CNT_HALF) begin
                            cnt     <= '0;
                            bit_idx <= '0;
                            // Line back high at mid start bit means a glitch.
                            state   <= rx_s ? IDLE : DATA;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end

                    DATA: begin
                        if (cnt == CNT_FULL) begin
                            cnt            <= '0;
                            shift[bit_idx] <= rx_s;
                            if (bit_idx == 3'd7) begin
                                state <= STOP;
                            end else begin
                                bit_idx <= bit_idx + 3'd1;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end

                    STOP: begin
                        if (cnt == CNT_FULL) begin
                            cnt <= '0;
                            if (rx_s) begin
                                data_out <= shift;
                                done     <= 1'b1;
                                ready    <= 1'b1;
                                // A simultaneous ack consumes the old byte, so
                                // overrun is neither set nor cleared then.
                                if (rd_ack) begin
                                    overrun <= overrun;
                                end else if (ready) begin
                                    overrun <= 1'b1;
                                end
                                state <= IDLE;
                            end else begin
                                frame_err <= 1'b1;
                                state     <= BREAK;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end

                    BREAK: begin
                        // Hold off until the line returns high so a stuck-low
                        // line cannot retrigger a start bit.
                        cnt <= '0;
                        if (rx_s) begin
                            state <= IDLE;
                        end
                    end

                    default: begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

endmodule
